// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative multiply/divide unit that owns the Hi/Lo register pair.
//   An operation is accepted from IDLE. It runs 32 iterations in CALC, one
//   per clock. It then spends one FIX cycle on sign correction and on loading
//   Hi/Lo. Every operation therefore takes 33 edges after the accept edge.
//
// Handshake: Start, HiWe, LoWe and HiLoRd are all sampled on a rising edge.
//   They take effect only while Busy=0, that is, in IDLE. While Busy=1 they
//   are ignored, and Stall is raised combinationally so that EX holds the
//   instruction until Busy drops.
//
// Ports
//   Clk, Rst    rising-edge clock; asynchronous active-high reset
//   Start, Op   request; Op encodes 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B        rs / rt operands
//   HiWe, LoWe  MTHI / MTLO strobes, with write data WData
//   HiLoRd      EX is executing MFHI/MFLO
//   Hi, Lo      register contents
//   Busy        operation in progress (CALC or FIX)
//   Done        one-cycle pulse after Hi/Lo are loaded by a finished operation
//   Stall       Busy & (Start | HiLoRd | HiWe | LoWe)
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WData,
  input  logic             HiLoRd,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;      // {hi half, lo half} working accumulator
  logic [WIDTH-1:0]     b_q;        // multiplicand or divisor magnitude
  logic                 is_mul_q;
  logic                 res_neg_q;  // negate product / quotient in FIX
  logic                 rem_neg_q;  // negate remainder in FIX
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;

  // Operand magnitudes. Unsigned ops (Op[0]=1) pass the raw operands through.
  logic             is_signed;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign is_signed = ~Op[0];
  assign a_abs = (is_signed & A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign b_abs = (is_signed & B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

  // Shift-add multiply. The multiplier sits in the low half and is consumed
  // LSB first. The partial product grows down from the top, with the carry
  // shifted in at bit 2*WIDTH-1.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide. The partial remainder is held in the high half. The
  // dividend shifts out of the low half MSB first, and quotient bits shift in
  // at the LSB. The partial remainder is always below the divisor, so after a
  // successful subtract the difference fits in WIDTH bits.
  logic [WIDTH:0]       div_rem;
  logic                 div_ok;
  logic [WIDTH-1:0]     div_sub;
  logic [2*WIDTH-1:0]   div_next;
  assign div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ok   = (div_rem >= {1'b0, b_q});
  assign div_sub  = div_rem[WIDTH-1:0] - b_q;
  assign div_next = {(div_ok ? div_sub : div_rem[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok};

  // Sign correction. The product is negated as a full 2*WIDTH value.
  // Quotient and remainder are each negated on their own half.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     fix_hi, fix_lo;
  always_comb begin
    prod_fix = res_neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    if (is_mul_q) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else begin
      fix_hi = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];
      fix_lo = res_neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_CALC;
      S_CALC:  if (cnt_q == '1) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_mul_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            // Start has priority, so a same-cycle MTHI/MTLO is dropped.
            acc_q     <= {{WIDTH{1'b0}}, a_abs};
            b_q       <= b_abs;
            is_mul_q  <= ~Op[1];
            res_neg_q <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            rem_neg_q <= is_signed & A[WIDTH-1];
            cnt_q     <= '0;
          end else begin
            if (HiWe) hi_q <= WData;
            if (LoWe) lo_q <= WData;
          end
        end
        S_CALC: begin
          acc_q <= is_mul_q ? mul_next : div_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Hi    = hi_q;
  assign Lo    = lo_q;
  assign Done  = done_q;
  assign Busy  = (state_q != S_IDLE);
  assign Stall = Busy & (Start | HiLoRd | HiWe | LoWe);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Testbench for mul_div_unit. It applies a table of directed vectors, a
//   set of random operations scored against an arithmetic reference model,
//   and hand-written sequences for the stall, MTHI/MTLO and reset corners.
//   Inputs are driven and outputs are sampled on the falling edge.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst, Start, HiWe, LoWe, HiLoRd;
  logic [1:0]   Op;
  logic [W-1:0] A, B, WData, Hi, Lo;
  logic         Busy, Done, Stall;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  mul_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWe(HiWe), .LoWe(LoWe), .WData(WData), .HiLoRd(HiLoRd),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic. Returns {Hi, Lo}.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      2'b10: begin
        if (b == 0) res = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  // Called on a falling edge while the unit is idle. Issues one op and
  // follows it through to completion.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input string name);
    int cycles;
    logic early_done;
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
    cycles = 0;
    early_done = 1'b0;
    while (Busy && cycles < 100) begin
      if (Done) early_done = 1'b1;
      cycles++;
      @(negedge Clk);
    end
    check({name, " busy_cycles"}, 64'(cycles), 64'd33);
    check({name, " early_done"}, 64'(early_done), 64'd0);
    check({name, " done"}, 64'(Done), 64'd1);
    check({name, " hi"}, 64'(Hi), 64'(eh));
    check({name, " lo"}, 64'(Lo), 64'(el));
    @(negedge Clk);
    check({name, " done_pulse_end"}, 64'(Done), 64'd0);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cyc;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    logic [63:0] e;

    vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[5] = '{2'b11, 32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF};
    vecs[6] = '{2'b10, 32'hFFFF_FFF0, 32'h0,         32'hFFFF_FFF0, 32'h1};
    vecs[7] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9] = '{2'b01, 32'h1_0000,    32'h1_0000,    32'h1,         32'h0};

    Rst = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    HiWe = 1'b0; LoWe = 1'b0; WData = '0; HiLoRd = 1'b0;
    #1;
    check("rst hi", 64'(Hi), 64'd0);
    check("rst lo", 64'(Lo), 64'd0);
    check("rst busy", 64'(Busy), 64'd0);
    check("rst done", 64'(Done), 64'd0);
    check("rst stall", 64'(Stall), 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    // ---------------- directed table ----------------
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // ---------------- randomized vs reference model ----------------
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
      exp_q.push_back(ref_md(rop, ra, rb));
      e = exp_q.pop_front();
      run_op(rop, ra, rb, e[63:32], e[31:0], $sformatf("rnd%0d op%0d", i, rop));
    end

    // ---------------- stall / ignored Start / ignored MTHI ----------------
    Start = 1'b1; Op = 2'b11; A = 32'd100; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Start = 1'b1; Op = 2'b00; A = 32'd5; B = 32'd5;
    HiLoRd = 1'b1; HiWe = 1'b1; WData = 32'hDEAD_BEEF;
    #1;
    check("busy start stall", 64'(Stall), 64'd1);
    @(negedge Clk);
    Start = 1'b0;
    cyc = 0;
    while (Busy && cyc < 100) begin
      #1;
      if (Stall !== 1'b1) check("stall held", 64'(Stall), 64'd1);
      @(negedge Clk);
      cyc++;
    end
    check("stall cycles", 64'(cyc), 64'd28);
    check("stall release", 64'(Stall), 64'd0);
    HiLoRd = 1'b0; HiWe = 1'b0;
    check("stall done", 64'(Done), 64'd1);
    check("stall hi", 64'(Hi), 64'd2);
    check("stall lo", 64'(Lo), 64'd14);
    @(negedge Clk);
    check("no restart busy", 64'(Busy), 64'd0);

    // ---------------- MTLO / MTHI in idle ----------------
    LoWe = 1'b1; WData = 32'h0000_ABCD;
    @(negedge Clk);
    LoWe = 1'b0;
    check("mtlo lo", 64'(Lo), 64'h0000_ABCD);
    check("mtlo hi kept", 64'(Hi), 64'd2);
    check("mtlo no done", 64'(Done), 64'd0);
    HiWe = 1'b1; LoWe = 1'b1; WData = 32'h1357_2468;
    @(negedge Clk);
    HiWe = 1'b0; LoWe = 1'b0;
    check("mt both hi", 64'(Hi), 64'h1357_2468);
    check("mt both lo", 64'(Lo), 64'h1357_2468);
    check("mt both no done", 64'(Done), 64'd0);

    // ---------------- Start beats a same-cycle MTHI ----------------
    HiWe = 1'b1; WData = 32'h5555_5555;
    Start = 1'b1; Op = 2'b01; A = 32'd2; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0; HiWe = 1'b0;
    check("start wins hi", 64'(Hi), 64'h1357_2468);
    cyc = 0;
    while (Busy && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    check("start wins lo", 64'(Lo), 64'd6);
    check("start wins hi res", 64'(Hi), 64'd0);
    @(negedge Clk);
    LoWe = 1'b1; WData = 32'h0000_ABCD;
    @(negedge Clk);
    LoWe = 1'b0;

    // ---------------- asynchronous reset mid-operation ----------------
    Start = 1'b1; Op = 2'b00; A = 32'd3; B = 32'd4;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    check("arst hi", 64'(Hi), 64'd0);
    check("arst lo", 64'(Lo), 64'd0);
    check("arst busy", 64'(Busy), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done || Busy) cyc++;
    end
    check("arst no done", 64'(cyc), 64'd0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "post rst mult");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
